// File: rtl/lsu_axi_stage_if.sv
// AXI4-Lite master bus used by the load/store stage.
// The master modport is the stage side; the slave modport is the memory side.
interface lsu_axi_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/lsu_axi_stage.sv
// EX->WB memory stage: turns loads/stores into AXI4-Lite transactions with
// sub-word lane alignment, and reports misaligned accesses and bus faults.
module lsu_axi_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [31:0]       in_inst,
  input  logic              in_mem_ren,
  input  logic              in_mem_wen,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_r_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_r_wen,
  output logic [ADDR_W-1:0] out_ex_result,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_misalign,
  output logic              out_fault,
  lsu_axi_stage_if.master   m
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, AR, R, W, B, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, addr_q;
  logic [31:0]       inst_q;
  logic [RD_W-1:0]   rd_q;
  logic              r_wen_q, mis_q, fault_q, aw_done_q, w_done_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, rshift, load_ext;
  logic [STRB_W-1:0] wstrb_q, cap_mask;
  logic [OFF_W-1:0]  cap_off;
  logic              capture, cap_mis, aw_fin, w_fin;

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign capture  = in_valid && in_ready;
  assign cap_off  = in_addr[OFF_W-1:0];

  // Alignment and byte-lane mask of the incoming access, judged before any bus activity
  always_comb begin
    cap_mis  = 1'b0;
    cap_mask = '0;
    case (in_funct3[1:0])
      2'd0: cap_mask = STRB_W'(8'h01);
      2'd1: begin
        cap_mask = STRB_W'(8'h03);
        cap_mis  = in_addr[0];
      end
      2'd2: begin
        cap_mask = STRB_W'(8'h0F);
        cap_mis  = (in_addr[1:0] != 2'b00);
      end
      default: begin
        cap_mask = STRB_W'(8'hFF);
        cap_mis  = (DATA_W == 32) || (in_addr[2:0] != 3'b000);
      end
    endcase
    if (in_mem_ren && in_funct3 == 3'b111) cap_mis = 1'b1;
    if (!in_mem_ren && !in_mem_wen) cap_mis = 1'b0;
  end

  assign aw_fin = aw_done_q || (m.awvalid && m.awready);
  assign w_fin  = w_done_q || (m.wvalid && m.wready);

  always_comb begin
    state_d = state_q;
    if (capture) begin
      if (cap_mis)         state_d = DONE;
      else if (in_mem_ren) state_d = AR;
      else if (in_mem_wen) state_d = W;
      else                 state_d = DONE;
    end else begin
      case (state_q)
        AR:      if (m.arready) state_d = R;
        R:       if (m.rvalid) state_d = DONE;
        W:       if (aw_fin && w_fin) state_d = B;
        B:       if (m.bvalid) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign rshift = m.rdata >> {off_q(addr_q), 3'b000};

  function automatic logic [OFF_W-1:0] off_q(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  always_comb begin
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = DATA_W'($signed(rshift[7:0]));
      3'b001:  load_ext = DATA_W'($signed(rshift[15:0]));
      3'b010:  load_ext = DATA_W'($signed(rshift[31:0]));
      3'b011:  load_ext = rshift;
      3'b100:  load_ext = DATA_W'(rshift[7:0]);
      3'b101:  load_ext = DATA_W'(rshift[15:0]);
      3'b110:  load_ext = DATA_W'(rshift[31:0]);
      default: load_ext = '0;
    endcase
  end

  // Fault and misalign both suppress the register write so WB never commits bad data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= '0;
      inst_q    <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      funct3_q  <= '0;
      r_wen_q   <= 1'b0;
      mis_q     <= 1'b0;
      fault_q   <= 1'b0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (capture) begin
        pc_q      <= in_pc;
        inst_q    <= in_inst;
        rd_q      <= in_rd;
        addr_q    <= in_addr;
        funct3_q  <= in_funct3;
        r_wen_q   <= in_r_wen && !cap_mis;
        mis_q     <= cap_mis;
        fault_q   <= 1'b0;
        rdata_q   <= '0;
        wdata_q   <= in_wdata << {cap_off, 3'b000};
        wstrb_q   <= cap_mask << cap_off;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (state_q == R && m.rvalid) begin
        fault_q <= (m.rresp != 2'b00);
        if (m.rresp != 2'b00) begin
          rdata_q <= '0;
          r_wen_q <= 1'b0;
        end else begin
          rdata_q <= load_ext;
        end
      end
      if (state_q == W) begin
        if (m.awvalid && m.awready) aw_done_q <= 1'b1;
        if (m.wvalid && m.wready)   w_done_q  <= 1'b1;
      end
      if (state_q == B && m.bvalid) fault_q <= (m.bresp != 2'b00);
    end
  end

  assign m.araddr  = addr_q;
  assign m.arvalid = (state_q == AR);
  assign m.rready  = (state_q == R);
  assign m.awaddr  = addr_q;
  assign m.awvalid = (state_q == W) && !aw_done_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.wvalid  = (state_q == W) && !w_done_q;
  assign m.bready  = (state_q == B);

  assign out_valid     = (state_q == DONE);
  assign out_pc        = pc_q;
  assign out_inst      = inst_q;
  assign out_rd        = rd_q;
  assign out_r_wen     = r_wen_q;
  assign out_ex_result = addr_q;
  assign out_rdata     = rdata_q;
  assign out_misalign  = mis_q;
  assign out_fault     = fault_q;
endmodule

// File: tb/tb_lsu_axi_stage.sv
// Directed bench for lsu_axi_stage: a 32-bit instance for the main paths and a
// 64-bit instance for doubleword and wide-lane loads.
module tb_lsu_axi_stage;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_valid64, in_ready64;
  logic [31:0] in_pc, in_inst, in_addr, in_wdata;
  logic [63:0] in_wdata64;
  logic        in_mem_ren, in_mem_wen, in_r_wen;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_r_wen, out_misalign, out_fault;
  logic [31:0] out_pc, out_inst, out_ex_result, out_rdata;
  logic [4:0]  out_rd;
  logic        out_valid64, out_ready64, r_wen64, misalign64, fault64;
  logic [31:0] pc64, inst64, ex64;
  logic [63:0] out_rdata64;
  logic [4:0]  rd64;
  int          checks, errors;

  lsu_axi_stage_if #(.ADDR_W(32), .DATA_W(32)) bus32 ();
  lsu_axi_stage_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

  lsu_axi_stage #(.ADDR_W(32), .DATA_W(32), .RD_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_r_wen(in_r_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rd(out_rd), .out_r_wen(out_r_wen), .out_ex_result(out_ex_result),
    .out_rdata(out_rdata), .out_misalign(out_misalign), .out_fault(out_fault),
    .m(bus32.master)
  );

  lsu_axi_stage #(.ADDR_W(32), .DATA_W(64), .RD_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_pc(in_pc), .in_inst(in_inst),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata64), .in_rd(in_rd), .in_r_wen(in_r_wen),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_pc(pc64), .out_inst(inst64),
    .out_rd(rd64), .out_r_wen(r_wen64), .out_ex_result(ex64),
    .out_rdata(out_rdata64), .out_misalign(misalign64), .out_fault(fault64),
    .m(bus64.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drainOutput();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic ren, input logic wen, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd, input logic rwen);
    in_mem_ren = ren;
    in_mem_wen = wen;
    in_funct3  = f3;
    in_addr    = addr;
    in_wdata   = wd;
    in_r_wen   = rwen;
    in_pc      = in_pc + 32'd4;
    in_inst    = 32'h0000_0013;
    in_rd      = 5'd7;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
  endtask

  // Zero-wait load through the 64-bit instance
  task automatic load64(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] rdata, input logic [63:0] exp);
    in_mem_ren = 1'b1;
    in_mem_wen = 1'b0;
    in_funct3  = f3;
    in_addr    = addr;
    in_r_wen   = 1'b1;
    in_valid64 = 1'b1;
    step();
    in_valid64    = 1'b0;
    bus64.arready = 1'b1;
    step();
    bus64.arready = 1'b0;
    bus64.rvalid  = 1'b1;
    bus64.rdata   = rdata;
    step();
    bus64.rvalid  = 1'b0;
    checkOutput({tag, "_valid"}, 64'(out_valid64), 64'd1);
    checkOutput({tag, "_rdata"}, out_rdata64, exp);
    checkOutput({tag, "_mis"}, 64'(misalign64), 64'd0);
    out_ready64 = 1'b1;
    step();
    out_ready64 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_valid64 = 1'b0; out_ready = 1'b0; out_ready64 = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0; in_addr = 32'h0; in_wdata = 32'h0; in_wdata64 = 64'h0;
    in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_r_wen = 1'b0; in_funct3 = 3'b0; in_rd = 5'd0;
    bus32.arready = 1'b0; bus32.rvalid = 1'b0; bus32.rdata = '0; bus32.rresp = 2'b00;
    bus32.awready = 1'b0; bus32.wready = 1'b0; bus32.bvalid = 1'b0; bus32.bresp = 2'b00;
    bus64.arready = 1'b0; bus64.rvalid = 1'b0; bus64.rdata = '0; bus64.rresp = 2'b00;
    bus64.awready = 1'b0; bus64.wready = 1'b0; bus64.bvalid = 1'b0; bus64.bresp = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    step();

    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_arvalid", 64'(bus32.arvalid), 64'd0);
    checkOutput("rst_awvalid", 64'(bus32.awvalid), 64'd0);
    checkOutput("rst_rdata", 64'(out_rdata), 64'd0);
    checkOutput("rst_pc", 64'(out_pc), 64'd0);

    // Four back-to-back non-memory instructions with the consumer always ready
    out_ready  = 1'b1;
    in_mem_ren = 1'b0;
    in_mem_wen = 1'b0;
    in_r_wen   = 1'b1;
    in_funct3  = 3'b000;
    for (int i = 0; i < 4; i++) begin
      in_pc    = 32'h0000_0100 + 32'(i * 4);
      in_addr  = 32'h0000_1000 + 32'(i);
      in_valid = 1'b1;
      step();
      checkOutput("nop_valid", 64'(out_valid), 64'd1);
      checkOutput("nop_in_ready", 64'(in_ready), 64'd1);
      checkOutput("nop_ex", 64'(out_ex_result), 64'h1000 + 64'(i));
      checkOutput("nop_pc", 64'(out_pc), 64'h100 + 64'(i * 4));
    end
    in_valid = 1'b0;
    step();
    checkOutput("nop_idle", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // lb with two wait cycles on both AR and R
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checkOutput("lb_arvalid_wait", 64'(bus32.arvalid), 64'd1);
      checkOutput("lb_araddr", 64'(bus32.araddr), 64'h8000_0003);
      step();
    end
    bus32.arready = 1'b1;
    step();
    bus32.arready = 1'b0;
    checkOutput("lb_arvalid_drop", 64'(bus32.arvalid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("lb_rready_hold", 64'(bus32.rready), 64'd1);
      step();
    end
    bus32.rvalid = 1'b1;
    bus32.rdata  = 32'h80FF_0000;
    step();
    bus32.rvalid = 1'b0;
    checkOutput("lb_valid", 64'(out_valid), 64'd1);
    checkOutput("lb_rdata", 64'(out_rdata), 64'hFFFF_FF80);
    checkOutput("lb_mis", 64'(out_misalign), 64'd0);
    checkOutput("lb_fault", 64'(out_fault), 64'd0);
    checkOutput("lb_rwen", 64'(out_r_wen), 64'd1);
    step();
    checkOutput("lb_hold_valid", 64'(out_valid), 64'd1);
    checkOutput("lb_hold_rdata", 64'(out_rdata), 64'hFFFF_FF80);
    drainOutput();

    // sh: W handshake lands one cycle before AW
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 1'b0);
    checkOutput("sh_wdata", 64'(bus32.wdata), 64'hABCD_0000);
    checkOutput("sh_wstrb", 64'(bus32.wstrb), 64'hC);
    checkOutput("sh_awaddr", 64'(bus32.awaddr), 64'h8000_0002);
    checkOutput("sh_both_valid", {62'd0, bus32.awvalid, bus32.wvalid}, 64'd3);
    bus32.wready = 1'b1;
    step();
    bus32.wready = 1'b0;
    checkOutput("sh_wvalid_drop", 64'(bus32.wvalid), 64'd0);
    checkOutput("sh_awvalid_hold", 64'(bus32.awvalid), 64'd1);
    bus32.awready = 1'b1;
    step();
    bus32.awready = 1'b0;
    checkOutput("sh_awvalid_drop", 64'(bus32.awvalid), 64'd0);
    checkOutput("sh_bready", 64'(bus32.bready), 64'd1);
    bus32.bvalid = 1'b1;
    step();
    bus32.bvalid = 1'b0;
    checkOutput("sh_valid", 64'(out_valid), 64'd1);
    checkOutput("sh_fault", 64'(out_fault), 64'd0);
    drainOutput();

    // Misaligned lw never reaches the bus
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0006, 32'h0, 1'b1);
    checkOutput("lwmis_valid", 64'(out_valid), 64'd1);
    checkOutput("lwmis_mis", 64'(out_misalign), 64'd1);
    checkOutput("lwmis_rwen", 64'(out_r_wen), 64'd0);
    checkOutput("lwmis_arvalid", 64'(bus32.arvalid), 64'd0);
    drainOutput();

    // lhu with SLVERR, then a clean store clears the fault
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h8000_0004, 32'h0, 1'b1);
    bus32.arready = 1'b1;
    step();
    bus32.arready = 1'b0;
    bus32.rvalid  = 1'b1;
    bus32.rresp   = 2'b10;
    bus32.rdata   = 32'hFFFF_FFFF;
    step();
    bus32.rvalid  = 1'b0;
    bus32.rresp   = 2'b00;
    checkOutput("lhu_fault", 64'(out_fault), 64'd1);
    checkOutput("lhu_rdata", 64'(out_rdata), 64'd0);
    checkOutput("lhu_rwen", 64'(out_r_wen), 64'd0);
    drainOutput();

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0);
    checkOutput("sw_wdata", 64'(bus32.wdata), 64'hDEAD_BEEF);
    checkOutput("sw_wstrb", 64'(bus32.wstrb), 64'hF);
    bus32.awready = 1'b1;
    bus32.wready  = 1'b1;
    step();
    bus32.awready = 1'b0;
    bus32.wready  = 1'b0;
    checkOutput("sw_bready", 64'(bus32.bready), 64'd1);
    bus32.bvalid = 1'b1;
    step();
    bus32.bvalid = 1'b0;
    checkOutput("sw_valid", 64'(out_valid), 64'd1);
    checkOutput("sw_fault", 64'(out_fault), 64'd0);
    drainOutput();

    // Reset while waiting in R
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 1'b1);
    bus32.arready = 1'b1;
    step();
    bus32.arready = 1'b0;
    checkOutput("rstR_rready", 64'(bus32.rready), 64'd1);
    rst_n = 1'b0;
    step();
    checkOutput("rstR_rready_drop", 64'(bus32.rready), 64'd0);
    checkOutput("rstR_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rstR_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    load64("ld64", 3'b011, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    load64("lwu64", 3'b110, 32'h0000_000C, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0123_4567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
